// File: rtl/cx_arbiter.sv
// Compare-exchange arbiter: fixed-priority grant of per-core CAS requests
// against a zero-initialised 2**N x 32 table.
package cx_arbiter_pkg;
    typedef logic [31:0] regval_t;
endpackage

module cx_arbiter
    import cx_arbiter_pkg::*;
#(
    parameter int unsigned CORES = 2,
    parameter int unsigned N     = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [CORES-1:0]        req,
    input  logic [CORES-1:0][N-1:0] index,
    input  regval_t [CORES-1:0]     comparand,
    input  regval_t [CORES-1:0]     replacement,
    output logic [CORES-1:0]        ack,
    output regval_t                 original,
    output logic                    exchanged,
    output logic                    busy
);

    localparam int unsigned DEPTH = 2 ** N;
    localparam int unsigned CW    = (CORES > 1) ? $clog2(CORES) : 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_COMMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     clr_ptr;
    logic [CORES-1:0] eligible;
    logic             grant_vld;
    logic [CW-1:0]    grant_id;
    logic [CW-1:0]    lat_core;
    logic [N-1:0]     lat_index;
    regval_t          lat_cmp;
    regval_t          lat_rep;
    regval_t          rd_data;
    logic             match;
    logic             mem_we;
    logic [N-1:0]     mem_wa;
    regval_t          mem_wd;
    logic [CORES-1:0] ack_nxt;
    regval_t          mem [DEPTH];

    // Next state, arbitration and table write port selection
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = '0;
        mem_we    = 1'b0;
        mem_wa    = '0;
        mem_wd    = '0;
        ack_nxt   = '0;
        eligible  = req & ~ack;
        match     = (rd_data == lat_cmp);

        // Descending scan so the lowest-numbered eligible core wins
        for (int i = int'(CORES) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_vld = 1'b1;
                grant_id  = CW'(i);
            end
        end

        for (int i = 0; i < int'(CORES); i++) begin
            ack_nxt[i] = (state == S_COMMIT) && (lat_core == CW'(i));
        end

        case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                if (clr_ptr == '1) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                mem_we    = match;
                mem_wa    = lat_index;
                mem_wd    = lat_rep;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_CLEAR;
            end
        endcase
    end

    // State, latched operation and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_CLEAR;
            clr_ptr   <= '0;
            ack       <= '0;
            original  <= '0;
            exchanged <= 1'b0;
            busy      <= 1'b1;
            lat_core  <= '0;
            lat_index <= '0;
            lat_cmp   <= '0;
            lat_rep   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            ack   <= ack_nxt;
            if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + N'(1);
            end
            if ((state == S_IDLE) && grant_vld) begin
                lat_core  <= grant_id;
                lat_index <= index[grant_id];
                lat_cmp   <= comparand[grant_id];
                lat_rep   <= replacement[grant_id];
            end
            if (state == S_COMMIT) begin
                original  <= rd_data;
                exchanged <= match;
            end
        end
    end

    // Table storage: one synchronous read port, one write port shared by CLEAR and COMMIT
    always_ff @(posedge clock) begin
        if (state == S_READ) begin
            rd_data <= mem[lat_index];
        end
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_cx_arbiter.sv
// Bench for cx_arbiter: directed scenarios plus randomized batches scored
// against a transaction-level table model.
module tb_cx_arbiter;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       req;
    logic [1:0][7:0]  index;
    logic [1:0][31:0] comparand;
    logic [1:0][31:0] replacement;
    logic [1:0]       ack;
    logic [31:0]      original;
    logic             exchanged;
    logic             busy;

    cx_arbiter #(.CORES(2), .N(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .index       (index),
        .comparand   (comparand),
        .replacement (replacement),
        .ack         (ack),
        .original    (original),
        .exchanged   (exchanged),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    logic [31:0] model [256];
    logic [31:0] last_orig;
    logic        last_x;
    logic [7:0]  op_idx [2];
    logic [31:0] op_cmp [2];
    logic [31:0] op_rep [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        last_orig = 32'h0;
        last_x    = 1'b0;
    endtask

    task automatic drive(input int c);
        req[c]         = 1'b1;
        index[c]       = op_idx[c];
        comparand[c]   = op_cmp[c];
        replacement[c] = op_rep[c];
    endtask

    task automatic expect_quiet(input logic exp_busy);
        chk("ack_quiet", 32'(ack), 32'h0);
        chk("original_hold", original, last_orig);
        chk("exchanged_hold", 32'(exchanged), 32'(last_x));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic expect_ack(input int c);
        logic [1:0]  ea;
        logic [31:0] exp_o;
        logic        exp_x;
        ea     = '0;
        ea[c]  = 1'b1;
        exp_o  = model[op_idx[c]];
        exp_x  = (exp_o == op_cmp[c]);
        chk("ack", 32'(ack), 32'(ea));
        chk("original", original, exp_o);
        chk("exchanged", 32'(exchanged), 32'(exp_x));
        chk("busy_ack", 32'(busy), 32'h0);
        if (exp_x) model[op_idx[c]] = op_rep[c];
        last_orig = exp_o;
        last_x    = exp_x;
    endtask

    // Cores in mask request together; served in ascending core order, one ack every 3 cycles
    task automatic run_batch(input logic [1:0] mask, input bit scramble);
        int         order[$];
        int         cyc;
        int         pos;
        logic [1:0] pend;
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                order.push_back(c);
                drive(c);
            end
        end
        pend = mask;
        cyc  = 0;
        pos  = 0;
        while (pend != 2'b00 && cyc < 30) begin
            step();
            cyc++;
            if (pos < order.size() && cyc == 3 * (pos + 1)) begin
                expect_ack(order[pos]);
                req[order[pos]]  = 1'b0;
                pend[order[pos]] = 1'b0;
                pos++;
            end else begin
                expect_quiet(1'b1);
                if (scramble && pos < order.size()) begin
                    index[order[pos]]       = 8'($urandom);
                    comparand[order[pos]]   = $urandom;
                    replacement[order[pos]] = $urandom;
                end
            end
        end
        if (pend != 2'b00) chk("batch_timeout", 32'(pend), 32'h0);
        req = '0;
        step();
        expect_quiet(1'b0);
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        chk("clear_len", 32'(n), 32'd256);
        expect_quiet(1'b0);
    endtask

    initial begin
        int sample_idx [4];
        reset_n     = 1'b1;
        req         = '0;
        index       = '0;
        comparand   = '0;
        replacement = '0;
        model_clear();

        // Reset values and CLEAR duration
        #2 reset_n = 1'b0;
        step();
        step();
        expect_quiet(1'b1);
        reset_n = 1'b1;
        wait_clear();

        // Freshly cleared entries read back as zero
        sample_idx[0] = 0;
        sample_idx[1] = 255;
        sample_idx[2] = 128;
        sample_idx[3] = int'($urandom_range(1, 254));
        for (int k = 0; k < 4; k++) begin
            op_idx[0] = 8'(sample_idx[k]);
            op_cmp[0] = 32'h0;
            op_rep[0] = 32'h0;
            run_batch(2'b01, 1'b0);
        end

        // Single-core exchange, failed exchange, table unchanged
        op_idx[0] = 8'd5; op_cmp[0] = 32'h0; op_rep[0] = 32'hDEADBEEF;
        run_batch(2'b01, 1'b0);
        op_cmp[0] = 32'h0; op_rep[0] = 32'h12345678;
        run_batch(2'b01, 1'b0);
        op_cmp[0] = 32'hDEADBEEF; op_rep[0] = 32'hDEADBEEF;
        run_batch(2'b01, 1'b0);

        // Simultaneous requests on the same entry
        op_idx[0] = 8'd7; op_cmp[0] = 32'h0; op_rep[0] = 32'h1;
        op_idx[1] = 8'd7; op_cmp[1] = 32'h0; op_rep[1] = 32'h2;
        run_batch(2'b11, 1'b0);

        // Core 0 holds req through its ack while core 1 waits
        op_idx[0] = 8'd9; op_cmp[0] = model[9];     op_rep[0] = 32'h11111111;
        op_idx[1] = 8'd9; op_cmp[1] = 32'h11111111; op_rep[1] = 32'h22222222;
        drive(0);
        drive(1);
        step(); expect_quiet(1'b1);
        step(); expect_quiet(1'b1);
        step(); expect_ack(0);
        op_cmp[0] = 32'h22222222; op_rep[0] = 32'h33333333;
        drive(0);
        step(); expect_quiet(1'b1);
        step(); expect_quiet(1'b1);
        step(); expect_ack(1);
        req[1] = 1'b0;
        step(); expect_quiet(1'b1);
        step(); expect_quiet(1'b1);
        step(); expect_ack(0);
        req[0] = 1'b0;
        step(); expect_quiet(1'b0);

        // Operands changed after the grant are ignored
        op_idx[1] = 8'd20; op_cmp[1] = model[20]; op_rep[1] = 32'hA5A5A5A5;
        run_batch(2'b10, 1'b1);
        op_idx[0] = 8'd20; op_cmp[0] = 32'hA5A5A5A5; op_rep[0] = 32'h5A5A5A5A;
        run_batch(2'b01, 1'b0);
        op_idx[0] = 8'd21; op_cmp[0] = 32'hFFFFFFFF; op_rep[0] = 32'h0;
        run_batch(2'b01, 1'b0);

        // Randomized batches
        for (int it = 0; it < 40; it++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            for (int c = 0; c < 2; c++) begin
                op_idx[c] = 8'($urandom_range(0, 15));
                op_cmp[c] = ($urandom_range(0, 1) == 1) ? model[op_idx[c]] : $urandom;
                op_rep[c] = $urandom;
            end
            run_batch(m, 1'($urandom_range(0, 1)));
        end

        // Reset in COMMIT with a matching comparand abandons the write
        op_idx[0] = 8'd11; op_cmp[0] = model[11]; op_rep[0] = 32'h55555555;
        drive(0);
        step(); expect_quiet(1'b1);
        step(); expect_quiet(1'b1);
        reset_n = 1'b0;
        #1;
        model_clear();
        expect_quiet(1'b1);
        req = '0;
        step();
        expect_quiet(1'b1);
        reset_n = 1'b1;
        wait_clear();
        op_idx[0] = 8'd11; op_cmp[0] = 32'hFFFFFFFF; op_rep[0] = 32'h0;
        run_batch(2'b01, 1'b0);
        op_idx[0] = 8'd5; op_cmp[0] = 32'hFFFFFFFF; op_rep[0] = 32'h0;
        run_batch(2'b01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
